// File: rtl/color_sched.sv
// Two-requester round-robin arbiter feeding the colouring stream; only legal colours are
// issued, and a starvation guard inserts a clear token to unblock a waiting requester.
module color_sched #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [1:0] color0,
    input  logic       req1,
    input  logic [1:0] color1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       out_valid,
    output logic [1:0] out_color,
    output logic       forced
);

    localparam logic [2:0] Limit = 3'(STARVE_LIMIT);

    logic       last_none_q;
    logic [1:0] last_q;
    logic [1:0] run_q;
    logic       ptr_q;
    logic [2:0] wait0_q;
    logic [2:0] wait1_q;

    logic       legal0, legal1;
    logic       starved0, starved1;
    logic       cand0, cand1;
    logic       force_clear;
    logic       g0, g1;
    logic [1:0] issue_color;

    function automatic logic is_legal(input logic [1:0] c, input logic none,
                                      input logic [1:0] last, input logic [1:0] run);
        if (c == 2'b11 || none) return 1'b1;
        if (c == last && run == 2'd2) return 1'b0;
        if ((last == 2'b00 && c == 2'b01) || (last == 2'b01 && c == 2'b00)) return 1'b0;
        return 1'b1;
    endfunction

    assign legal0      = is_legal(color0, last_none_q, last_q, run_q);
    assign legal1      = is_legal(color1, last_none_q, last_q, run_q);
    assign starved0    = req0 && (wait0_q == Limit);
    assign starved1    = req1 && (wait1_q == Limit);
    assign cand0       = req0 && legal0;
    assign cand1       = req1 && legal1;
    assign force_clear = (starved0 && !legal0) || (starved1 && !legal1);

    // A starved requester with a legal colour overrides the round-robin pointer.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!force_clear) begin
            if (starved0 && legal0 && starved1 && legal1) begin
                g0 = !ptr_q;
                g1 = ptr_q;
            end else if (starved0 && legal0) begin
                g0 = 1'b1;
            end else if (starved1 && legal1) begin
                g1 = 1'b1;
            end else if (cand0 && cand1) begin
                g0 = !ptr_q;
                g1 = ptr_q;
            end else begin
                g0 = cand0;
                g1 = cand1;
            end
        end
    end

    assign gnt0        = g0 && rst_n;
    assign gnt1        = g1 && rst_n;
    assign issue_color = g1 ? color1 : color0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_color   <= 2'b00;
            forced      <= 1'b0;
            last_none_q <= 1'b1;
            last_q      <= 2'b00;
            run_q       <= 2'd0;
            ptr_q       <= 1'b0;
            wait0_q     <= 3'd0;
            wait1_q     <= 3'd0;
        end else if (force_clear) begin
            // Wait counters hold so the starved requester keeps its priority.
            out_valid   <= 1'b1;
            out_color   <= 2'b11;
            forced      <= 1'b1;
            last_none_q <= 1'b1;
            run_q       <= 2'd0;
            ptr_q       <= (starved0 && starved1) ? ptr_q : starved1;
        end else begin
            forced    <= 1'b0;
            out_valid <= g0 || g1;
            wait0_q   <= (!req0 || g0) ? 3'd0 : ((wait0_q == Limit) ? wait0_q : wait0_q + 3'd1);
            wait1_q   <= (!req1 || g1) ? 3'd0 : ((wait1_q == Limit) ? wait1_q : wait1_q + 3'd1);
            if (g0 || g1) begin
                out_color <= issue_color;
                ptr_q     <= g0;
                if (issue_color == 2'b11) begin
                    last_none_q <= 1'b1;
                    run_q       <= 2'd0;
                end else if (!last_none_q && issue_color == last_q) begin
                    run_q <= run_q + 2'd1;
                end else begin
                    last_none_q <= 1'b0;
                    last_q      <= issue_color;
                    run_q       <= 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_sched.sv
// Bench for color_sched: directed scenarios plus a randomized run against a queue-based
// model of the issued colour history.
module tb_color_sched;

    localparam int unsigned Limit = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic [1:0] color0 = 2'b00;
    logic       req1 = 1'b0;
    logic [1:0] color1 = 2'b00;
    logic       gnt0, gnt1, out_valid, forced;
    logic [1:0] out_color;

    int total = 0;
    int bad = 0;

    color_sched #(.STARVE_LIMIT(Limit)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .color0    (color0),
        .req1      (req1),
        .color1    (color1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .out_valid (out_valid),
        .out_color (out_color),
        .forced    (forced)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req0   = 1'b0;
        req1   = 1'b0;
        color0 = 2'b00;
        color1 = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Legality from the list of colours issued since the last clear.
    function automatic bit legal_m(input int h[$], input int c);
        int n;
        n = h.size();
        if (c == 3 || n == 0) return 1'b1;
        if (n >= 2 && h[n-1] == c && h[n-2] == c) return 1'b0;
        if ((h[n-1] == 0 && c == 1) || (h[n-1] == 1 && c == 0)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset;
        rst_n  = 1'b0;
        req0   = 1'b1;
        color0 = 2'b00;
        req1   = 1'b1;
        color1 = 2'b10;
        @(negedge clk);
        total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%b want=0", gnt0); end
        total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%b want=0", gnt1); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_color !== 2'b00) begin bad++; $display("FAIL reset_color got=%b want=00", out_color); end
        total++; if (forced !== 1'b0) begin bad++; $display("FAIL reset_forced got=%b want=0", forced); end
        #2 rst_n = 1'b1;
        #1;
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL reset_first_gnt0 got=%b want=1", gnt0); end
        total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL reset_first_gnt1 got=%b want=0", gnt1); end
        tick();
        req0 = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_out_valid got=%b want=1", out_valid); end
        total++; if (out_color !== 2'b00) begin bad++; $display("FAIL reset_out_color got=%b want=00", out_color); end
        total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL reset_next_gnt1 got=%b want=1", gnt1); end
        tick();
        req1 = 1'b0;
    endtask

    task automatic test_run_limit;
        int eg[9];
        int ev[9];
        int ec[9];
        int ef[9];
        eg = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        ev = '{0, 1, 1, 0, 0, 0, 0, 1, 1};
        ec = '{0, 0, 0, 0, 0, 0, 0, 3, 0};
        ef = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        do_reset();
        req0   = 1'b1;
        color0 = 2'b00;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            total++; if (gnt0 !== 1'(eg[k])) begin bad++; $display("FAIL starve_gnt0[%0d] got=%b want=%0d", k, gnt0, eg[k]); end
            total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL starve_gnt1[%0d] got=%b want=0", k, gnt1); end
            total++; if (out_valid !== 1'(ev[k])) begin bad++; $display("FAIL starve_valid[%0d] got=%b want=%0d", k, out_valid, ev[k]); end
            total++; if (out_color !== 2'(ec[k])) begin bad++; $display("FAIL starve_color[%0d] got=%0d want=%0d", k, out_color, ec[k]); end
            total++; if (forced !== 1'(ef[k])) begin bad++; $display("FAIL starve_forced[%0d] got=%b want=%0d", k, forced, ef[k]); end
            tick();
        end
        req0 = 1'b0;
    endtask

    task automatic test_round_robin;
        int eg0[5];
        int ev[5];
        int ec[5];
        eg0 = '{1, 0, 1, 0, 1};
        ev  = '{0, 1, 1, 1, 1};
        ec  = '{0, 0, 2, 0, 2};
        do_reset();
        req0   = 1'b1;
        color0 = 2'b00;
        req1   = 1'b1;
        color1 = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (gnt0 !== 1'(eg0[k])) begin bad++; $display("FAIL rr_gnt0[%0d] got=%b want=%0d", k, gnt0, eg0[k]); end
            total++; if (gnt1 !== !1'(eg0[k])) begin bad++; $display("FAIL rr_gnt1[%0d] got=%b want=%0d", k, gnt1, 1 - eg0[k]); end
            total++; if (out_valid !== 1'(ev[k])) begin bad++; $display("FAIL rr_valid[%0d] got=%b want=%0d", k, out_valid, ev[k]); end
            total++; if (out_color !== 2'(ec[k])) begin bad++; $display("FAIL rr_color[%0d] got=%0d want=%0d", k, out_color, ec[k]); end
            total++; if (forced !== 1'b0) begin bad++; $display("FAIL rr_forced[%0d] got=%b want=0", k, forced); end
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_red_green;
        do_reset();
        req0   = 1'b1;
        color0 = 2'b00;
        @(negedge clk);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL rg_gnt0_first got=%b want=1", gnt0); end
        tick();
        color0 = 2'b10;
        req1   = 1'b1;
        color1 = 2'b01;
        @(negedge clk);
        total++; if (out_color !== 2'b00 || out_valid !== 1'b1) begin bad++; $display("FAIL rg_out0 got=%b/%0d want=1/0", out_valid, out_color); end
        total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL rg_block got=%b%b want=01", gnt1, gnt0); end
        tick();
        req0 = 1'b0;
        @(negedge clk);
        total++; if (out_color !== 2'b10 || out_valid !== 1'b1) begin bad++; $display("FAIL rg_out1 got=%b/%0d want=1/2", out_valid, out_color); end
        total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL rg_gnt1 got=%b want=1", gnt1); end
        tick();
        req1 = 1'b0;
        @(negedge clk);
        total++; if (out_color !== 2'b01 || out_valid !== 1'b1) begin bad++; $display("FAIL rg_out2 got=%b/%0d want=1/1", out_valid, out_color); end
    endtask

    task automatic test_clear_legal;
        do_reset();
        req0   = 1'b1;
        color0 = 2'b01;
        @(negedge clk);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL clr_gnt_a got=%b want=1", gnt0); end
        tick();
        @(negedge clk);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL clr_gnt_b got=%b want=1", gnt0); end
        tick();
        color0 = 2'b11;
        req1   = 1'b1;
        color1 = 2'b01;
        @(negedge clk);
        total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL clr_pick got=%b%b want=01", gnt1, gnt0); end
        total++; if (out_color !== 2'b01) begin bad++; $display("FAIL clr_out01 got=%0d want=1", out_color); end
        tick();
        req0 = 1'b0;
        @(negedge clk);
        total++; if (out_color !== 2'b11 || forced !== 1'b0) begin bad++; $display("FAIL clr_out11 got=%0d/%b want=3/0", out_color, forced); end
        total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL clr_gnt1 got=%b want=1", gnt1); end
        tick();
        req1 = 1'b0;
        @(negedge clk);
        total++; if (out_color !== 2'b01 || out_valid !== 1'b1) begin bad++; $display("FAIL clr_final got=%b/%0d want=1/1", out_valid, out_color); end
    endtask

    task automatic test_async_reset;
        do_reset();
        req0   = 1'b1;
        color0 = 2'b00;
        @(negedge clk);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL ar_gnt_pre got=%b want=1", gnt0); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_valid_pre got=%b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_color !== 2'b00) begin bad++; $display("FAIL ar_outs got=%b/%0d want=0/0", out_valid, out_color); end
        total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL ar_gnt_low got=%b want=0", gnt0); end
        #2 rst_n = 1'b1;
        @(negedge clk);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL ar_gnt_a got=%b want=1", gnt0); end
        tick();
        @(negedge clk);
        total++; if (gnt0 !== 1'b1 || out_color !== 2'b00) begin bad++; $display("FAIL ar_gnt_b got=%b/%0d want=1/0", gnt0, out_color); end
        tick();
        @(negedge clk);
        total++; if (gnt0 !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL ar_block got=%b/%b want=0/1", gnt0, out_valid); end
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_idle got=%b want=0", out_valid); end
        req0 = 1'b0;
    endtask

    task automatic test_random;
        int  hist[$];
        int  seen[$];
        int  mptr, mw0, mw1, eoc, pick;
        bit  eov, ef, l0, l1, s0, s1, frc, c0, c1, eg0, eg1, pend0, pend1;
        hist.delete();
        seen.delete();
        mptr = 0; mw0 = 0; mw1 = 0; eov = 0; eoc = 0; ef = 0; pend0 = 0; pend1 = 0;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            l0  = legal_m(hist, int'(color0));
            l1  = legal_m(hist, int'(color1));
            s0  = req0 && (mw0 == Limit);
            s1  = req1 && (mw1 == Limit);
            frc = (s0 && !l0) || (s1 && !l1);
            c0  = req0 && l0;
            c1  = req1 && l1;
            // Starved candidates, if any, are the only ones considered.
            if ((s0 && c0) || (s1 && c1)) begin
                c0 = s0 && c0;
                c1 = s1 && c1;
            end
            eg0 = !frc && c0 && (!c1 || mptr == 0);
            eg1 = !frc && c1 && (!c0 || mptr == 1);
            total++; if (gnt0 !== eg0) begin bad++; $display("FAIL rnd_gnt0 cyc=%0d got=%b want=%b", cyc, gnt0, eg0); end
            total++; if (gnt1 !== eg1) begin bad++; $display("FAIL rnd_gnt1 cyc=%0d got=%b want=%b", cyc, gnt1, eg1); end
            total++; if (out_valid !== eov) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, out_valid, eov); end
            total++; if (out_color !== 2'(eoc)) begin bad++; $display("FAIL rnd_color cyc=%0d got=%0d want=%0d", cyc, out_color, eoc); end
            total++; if (forced !== ef) begin bad++; $display("FAIL rnd_forced cyc=%0d got=%b want=%b", cyc, forced, ef); end
            if (out_valid === 1'b1) begin
                total++;
                if (!legal_m(seen, int'(out_color))) begin
                    bad++;
                    $display("FAIL rnd_stream_legal cyc=%0d got=%0d want=legal", cyc, out_color);
                end
                if (out_color == 2'b11) seen.delete();
                else seen.push_back(int'(out_color));
                if (seen.size() > 4) void'(seen.pop_front());
            end
            if (frc) begin
                hist.delete();
                mptr = (s0 && s1) ? mptr : (s1 ? 1 : 0);
                eov = 1; eoc = 3; ef = 1;
            end else begin
                ef  = 0;
                eov = eg0 || eg1;
                if (eg0 || eg1) begin
                    eoc  = eg1 ? int'(color1) : int'(color0);
                    mptr = eg0 ? 1 : 0;
                    if (eoc == 3) hist.delete();
                    else hist.push_back(eoc);
                    if (hist.size() > 4) void'(hist.pop_front());
                end
                mw0 = (!req0 || eg0) ? 0 : ((mw0 < Limit) ? mw0 + 1 : mw0);
                mw1 = (!req1 || eg1) ? 0 : ((mw1 < Limit) ? mw1 + 1 : mw1);
            end
            tick();
            if (eg0) pend0 = 0;
            if (eg1) pend1 = 0;
            if (pend0 && $urandom_range(15) == 0) pend0 = 0;
            else if (!pend0 && $urandom_range(1) == 1) begin
                pend0  = 1;
                pick   = int'($urandom_range(9));
                color0 = (pick == 9) ? 2'd3 : 2'(pick % 3);
            end
            if (pend1 && $urandom_range(15) == 0) pend1 = 0;
            else if (!pend1 && $urandom_range(1) == 1) begin
                pend1  = 1;
                pick   = int'($urandom_range(9));
                color1 = (pick == 9) ? 2'd3 : 2'(pick % 3);
            end
            req0 = pend0;
            req1 = pend1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_limit();
        test_round_robin();
        test_red_green();
        test_clear_legal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
